calc_sequencer: RTL
===================

# calc_sequencer

Sequential front end for the six-bit combinational `calculator` datapath. It accepts operation commands over a valid/ready handshake and buffers them in a small FIFO. It drives the calculator's operand and operator inputs, holds them stable for a programmable settle window, then captures result and error into a response register with its own valid/ready handshake. It keeps a running accumulator so that commands can chain on the previous result. It sits between the command source (keypad/host logic) and the calculator instance, which is wired to the `calc_*` ports at the top level.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `SETTLE`, 2: cycles operands are held before capture; ≥1.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_a`, `cmd_b`  in  6 each  operands.
- `cmd_op`  in  4  operator code (0 add … 11 tan).
- `cmd_chain`  in  1  use `acc` instead of `cmd_a` as operand A.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  6  captured result.
- `rsp_error`  out  1  captured error.
- `calc_a`, `calc_b`  out  6 each  to calculator `data_in1`/`data_in2`.
- `calc_op`  out  4  to calculator `operator`.
- `calc_out`  in  6  from calculator `data_out`.
- `calc_err`  in  1  from calculator `error`.
- `acc`  out  6  accumulator, last error-free result.
- `busy`  out  1  FSM not IDLE or FIFO non-empty.

## Operation
- **Push.** A command is pushed when `cmd_valid && cmd_ready`. `cmd_ready = !full`, derived from the registered count. There is no push-while-full bypass.
- **FSM states.**
  - IDLE: if the FIFO is non-empty, pop it, load `calc_a`/`calc_b`/`calc_op`, load the settle counter with `SETTLE-1`, and go to SETTLE.
  - SETTLE: decrement the counter. When it reaches 0, capture into `rsp_data`/`rsp_error`, set `rsp_valid`, and go to RESP.
  - RESP: hold until `rsp_ready`. On the handshake, clear `rsp_valid`. If the FIFO is non-empty, pop and load in the same cycle and go to SETTLE; otherwise go to IDLE.
- **Operand A at pop.** `calc_a = cmd_chain ? acc : cmd_a`. `acc` is sampled at the pop edge, so a chained command sees the result of its predecessor, because capture always precedes the next pop.
- **Invalid operators.** Codes 6 (log, not implemented) and 12–15 capture `rsp_data=0`, `rsp_error=1` regardless of `calc_err`. The timing is unchanged.
- **Accumulator.** At capture, `acc ← captured data` only if captured error = 0. Otherwise `acc` is unchanged.
- **Held outputs.** `calc_*` hold their last values in IDLE and RESP.
- **FIFO.** Circular with wrap-around pointers of `$clog2(DEPTH)` bits and a `$clog2(DEPTH)+1`-bit count. Simultaneous push and pop is legal whenever not full, and leaves the count unchanged.
- **Reset (asynchronous).** All registers and outputs go to 0: `rsp_valid`, `rsp_data`, `rsp_error`, `calc_*`, `acc`, `busy`, and the FIFO pointers and count. `cmd_ready` is 1 during and after reset. Reset mid-operation flushes the FIFO and drops any in-flight or held response.

## Timing
- Accept at edge k with an empty FIFO and the FSM in IDLE:
  - pop and load at edge k+1;
  - capture at edge k+1+SETTLE;
  - `rsp_valid` is high from that edge on.
- Back-to-back throughput: one response per SETTLE+1 cycles when `rsp_ready` is held high.
- `rsp_*` are stable while `rsp_valid && !rsp_ready`.
- `cmd_ready` falls on the edge at which the count reaches DEPTH.

## Structure
- Shared package `calc_pkg`:
  - opcode constants `OP_ADD=0`, `OP_SUB=1`, `OP_MUL=2`, `OP_DIV=3`, `OP_MOD=4`, `OP_POW=5`, `OP_LOG=6`, `OP_FACT=7`, `OP_EXP=8`, `OP_SIN=9`, `OP_COS=10`, `OP_TAN=11`;
  - `DATA_W=6`, `OP_W=4`;
  - an FSM state enum;
  - an `is_valid_op` function.
- One sub-module, `calc_cmd_fifo`: parameterised `DEPTH`, entry width `2*DATA_W+OP_W+1`, push/pop/full/empty ports.
- The calculator is not instantiated inside this block.

## Test plan
- **Single add.** Drive `cmd_a=5`, `cmd_b=9`, `op=0` with the bench modelling the calculator. Required: `rsp_data=14`, `rsp_error=0`, `rsp_valid` SETTLE+1 edges after accept, `acc=14`.
- **Chain.** Send `add 3+4`, then `mul chain b=2`. Required: second `calc_a=7`, `rsp_data=14`. Then send `sub chain b=20` with the model flagging error. Required: `rsp_error=1`, `acc` stays 14.
- **Invalid op.** Send `cmd_op=13` while the model drives `calc_err=0` and `calc_out=63`. Required: `rsp_data=0`, `rsp_error=1`, `acc` unchanged.
- **Full FIFO.** Hold `rsp_ready=0` and push DEPTH+2 commands. Required: `cmd_ready=0` after the FIFO fills, no loss or duplication, and responses emitted in order with `rsp_*` stable while stalled.
- **Simultaneous events.** Push in the same cycle as a RESP→SETTLE pop with the FIFO at DEPTH-1. Required: count unchanged, `cmd_ready` stays 1.
- **Reset mid-operation.** Assert `rst_n=0` during SETTLE with 3 commands queued. Required: all outputs 0 immediately, `cmd_ready=1`, and no response after release until new commands are pushed.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator sequencer.
//   - datapath widths and calculator opcode constants
//   - sequencer FSM state type
//   - packed command record as stored in the command FIFO
//   - is_valid_op(): true for opcodes the calculator implements
package calc_pkg;

   localparam int unsigned DATA_W = 6;
   localparam int unsigned OP_W   = 4;

   localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
   localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
   localparam logic [OP_W-1:0] OP_MUL  = 4'd2;
   localparam logic [OP_W-1:0] OP_DIV  = 4'd3;
   localparam logic [OP_W-1:0] OP_MOD  = 4'd4;
   localparam logic [OP_W-1:0] OP_POW  = 4'd5;
   localparam logic [OP_W-1:0] OP_LOG  = 4'd6;
   localparam logic [OP_W-1:0] OP_FACT = 4'd7;
   localparam logic [OP_W-1:0] OP_EXP  = 4'd8;
   localparam logic [OP_W-1:0] OP_SIN  = 4'd9;
   localparam logic [OP_W-1:0] OP_COS  = 4'd10;
   localparam logic [OP_W-1:0] OP_TAN  = 4'd11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } seq_state_t;

   // FIFO entry: 2*DATA_W + OP_W + 1 bits
   typedef struct packed {
      logic              chain;
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] a;
   } cmd_t;

   // LOG is reserved but unimplemented; 12..15 are unassigned
   function automatic logic is_valid_op(input logic [OP_W-1:0] op);
      return (op <= OP_TAN) && (op != OP_LOG);
   endfunction

endpackage

// File: rtl/calc_cmd_fifo.sv
// calc_cmd_fifo: circular command FIFO with show-ahead read.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data (ignored when full)
//   push_data   : entry to write
//   pop         : discard head entry (ignored when empty)
//   pop_data    : current head entry
//   full, empty : derived from the registered count
module calc_cmd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 17
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // storage carries no reset; only pointers and count define contents
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: sequential front end for the combinational calculator.
//   clk, rst_n           : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake into the FIFO
//   cmd_a, cmd_b, cmd_op : operands and operator code
//   cmd_chain            : take operand A from acc instead of cmd_a
//   rsp_valid/rsp_ready  : response handshake
//   rsp_data, rsp_error  : captured result and error
//   calc_a/b/op          : drive the calculator inputs
//   calc_out, calc_err   : calculator outputs
//   acc                  : last error-free result
//   busy                 : FSM active or FIFO non-empty
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned SETTLE = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic [OP_W-1:0]   cmd_op,
   input  logic              cmd_chain,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_error,
   output logic [DATA_W-1:0] calc_a,
   output logic [DATA_W-1:0] calc_b,
   output logic [OP_W-1:0]   calc_op,
   input  logic [DATA_W-1:0] calc_out,
   input  logic              calc_err,
   output logic [DATA_W-1:0] acc,
   output logic              busy
);

   localparam int unsigned SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   seq_state_t        state_q;
   seq_state_t        state_d;
   logic [SCNT_W-1:0] settle_cnt;

   cmd_t              new_cmd;
   cmd_t              head_cmd;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic              capture;
   logic              rsp_take;
   logic              op_ok;
   logic [DATA_W-1:0] cap_data;
   logic              cap_err;

   always_comb begin
      new_cmd       = '0;
      new_cmd.chain = cmd_chain;
      new_cmd.op    = cmd_op;
      new_cmd.b     = cmd_b;
      new_cmd.a     = cmd_a;
   end

   assign cmd_ready = !fifo_full;
   assign push      = cmd_valid && !fifo_full;

   calc_cmd_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(cmd_t))
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (new_cmd),
      .pop       (pop),
      .pop_data  (head_cmd),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (settle_cnt == '0) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = fifo_empty ? ST_IDLE : ST_SETTLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // control outputs
   always_comb begin
      pop      = 1'b0;
      capture  = 1'b0;
      rsp_take = 1'b0;
      case (state_q)
         ST_IDLE: begin
            pop = !fifo_empty;
         end
         ST_SETTLE: begin
            capture = (settle_cnt == '0);
         end
         ST_RESP: begin
            rsp_take = rsp_ready;
            pop      = rsp_ready && !fifo_empty;
         end
         default: ;
      endcase
   end

   // unimplemented opcodes force a zero result with error, ignoring the calculator
   always_comb begin
      op_ok    = is_valid_op(calc_op);
      cap_data = op_ok ? calc_out : '0;
      cap_err  = op_ok ? calc_err : 1'b1;
   end

   // operand registers, settle counter, response and accumulator
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         calc_a     <= '0;
         calc_b     <= '0;
         calc_op    <= '0;
         settle_cnt <= '0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_error  <= 1'b0;
         acc        <= '0;
      end else begin
         if (pop) begin
            // acc already holds the predecessor's result: capture precedes any pop
            calc_a     <= head_cmd.chain ? acc : head_cmd.a;
            calc_b     <= head_cmd.b;
            calc_op    <= head_cmd.op;
            settle_cnt <= SCNT_W'(SETTLE - 1);
         end else if ((state_q == ST_SETTLE) && (settle_cnt != '0)) begin
            settle_cnt <= settle_cnt - SCNT_W'(1);
         end

         if (capture) begin
            rsp_valid <= 1'b1;
            rsp_data  <= cap_data;
            rsp_error <= cap_err;
            if (!cap_err) begin
               acc <= cap_data;
            end
         end else if (rsp_take) begin
            rsp_valid <= 1'b0;
         end
      end
   end

   assign busy = (state_q != ST_IDLE) || !fifo_empty;

endmodule
